sprite_line_engine: RTL and testbench

SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_line_buffer.sv | 48 ++++
 rtl/sprite_line_engine.sv | 186 ++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, sprite attribute record and prefetch FSM states
package sprite_pkg;

    localparam int NUM_SPRITES = 8;
    localparam int SPRITE_DIM  = 16;
    localparam int H_ACTIVE    = 640;
    localparam int V_LAST      = 524;

    // Field order matches the table write word {enable, x, y, icon}.
    typedef struct packed {
        logic       enable;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] icon;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_DRAIN
    } sprite_state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// rtl/sprite_line_buffer.sv - 640x5 line buffer with read/clear port and masked write port
//   clk, rst_n          : clock, synchronous active-low reset (read register only)
//   rd_en/rd_addr       : read entry and clear it to 0 in the same cycle
//   rd_data             : entry read on the previous cycle, 0 when no read was issued
//   wr_en/wr_addr/wr_data : write port
//   wr_force            : 1 writes unconditionally, 0 writes only over a non-opaque entry
module sprite_line_buffer
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_en,
    input  logic [9:0] rd_addr,
    output logic [4:0] rd_data,
    input  logic       wr_en,
    input  logic       wr_force,
    input  logic [9:0] wr_addr,
    input  logic [4:0] wr_data
);

    logic [4:0] mem [H_ACTIVE];
    logic       wr_ok;

    // An opaque entry already present belongs to a lower slot and must survive.
    // The display clear wins over a write to the same address.
    always_comb begin
        wr_ok = wr_en && (wr_force || !mem[wr_addr][4])
                && !(rd_en && (rd_addr == wr_addr));
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            mem[rd_addr] <= '0;
        end
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - per-line sprite prefetch into a line buffer with display readout
//   clk, rst_n              : pixel clock, synchronous active-low reset
//   hcount, vcount          : current display column / line
//   new_line                : pulse at hcount==640, starts the prefetch for the next line
//   tbl_we/tbl_addr/tbl_data: sprite table write {enable, x, y, icon}
//   rom_addr, rom_data      : sprite ROM {icon,row,col} -> {opaque,index}, 1-cycle latency
//   sprite_pixel(_active)   : palette index / opacity, 1 cycle after hcount
//   busy                    : prefetch FSM not idle
//   overrun                 : sticky, a prefetch was cut off by the start of the next line
module sprite_line_engine
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        new_line,
    input  logic        tbl_we,
    input  logic [2:0]  tbl_addr,
    input  logic [24:0] tbl_data,
    output logic [11:0] rom_addr,
    input  logic [4:0]  rom_data,
    output logic [3:0]  sprite_pixel,
    output logic        sprite_pixel_active,
    output logic        busy,
    output logic        overrun
);

    sprite_state_t state;
    sprite_state_t state_nxt;
    sprite_attr_t  sprite_tbl [NUM_SPRITES];
    sprite_attr_t  cur;

    logic [9:0]  clr_cnt;
    logic [9:0]  target;
    logic [2:0]  slot;
    logic [3:0]  col;
    logic [9:0]  x_q;
    logic [3:0]  icon_q;
    logic [3:0]  row_q;
    logic        pend_v;
    logic [10:0] pend_xcol;

    logic [10:0] dy;
    logic        hit;
    logic        abort;
    logic        last_slot;
    logic        in_blank;

    logic        rd_en;
    logic [4:0]  rd_data;
    logic        wr_en;
    logic        wr_force;
    logic [9:0]  wr_addr;
    logic [4:0]  wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sprite_tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            sprite_tbl[tbl_addr] <= sprite_attr_t'(tbl_data);
        end
    end

    // dy is 11 bits so a sprite starting below the target line shows up as a
    // borrow instead of aliasing to a small row number.
    always_comb begin
        cur       = sprite_tbl[slot];
        dy        = {1'b0, target} - {1'b0, cur.y};
        hit       = cur.enable && !dy[10] && (dy[9:0] < 10'(SPRITE_DIM));
        last_slot = (slot == 3'(NUM_SPRITES - 1));
        in_blank  = (hcount >= 10'(H_ACTIVE));
        abort     = (hcount == 10'd0) && (state != ST_IDLE) && (state != ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == 10'(H_ACTIVE - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (new_line) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (hit)       state_nxt = ST_FETCH;
                else if (last_slot) state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
                if (abort)                              state_nxt = ST_IDLE;
                else if (col == 4'(SPRITE_DIM - 1))     state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (last_slot) state_nxt = ST_IDLE;
                else                state_nxt = ST_CHECK;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        rom_addr = (state == ST_FETCH) ? {icon_q, row_q, col} : 12'd0;
        // Display reads are suppressed while the buffer is still being cleared.
        rd_en    = !in_blank && (state != ST_CLEAR);
        if (state == ST_CLEAR) begin
            wr_en    = 1'b1;
            wr_force = 1'b1;
            wr_addr  = clr_cnt;
            wr_data  = '0;
        end else begin
            // ROM word returns one cycle after its address; fills land only in blank.
            wr_en    = pend_v && rom_data[4] && (pend_xcol < 11'(H_ACTIVE)) && in_blank;
            wr_force = 1'b0;
            wr_addr  = pend_xcol[9:0];
            wr_data  = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            target    <= '0;
            slot      <= '0;
            col       <= '0;
            x_q       <= '0;
            icon_q    <= '0;
            row_q     <= '0;
            pend_v    <= 1'b0;
            pend_xcol <= '0;
            overrun   <= 1'b0;
        end else begin
            pend_v    <= (state == ST_FETCH);
            pend_xcol <= {1'b0, x_q} + {7'd0, col};
            if (abort) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_CLEAR: clr_cnt <= clr_cnt + 10'd1;
                ST_IDLE: begin
                    if (new_line) begin
                        target <= (vcount == 10'(V_LAST)) ? 10'd0 : vcount + 10'd1;
                        slot   <= '0;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        x_q    <= cur.x;
                        icon_q <= cur.icon;
                        row_q  <= dy[3:0];
                        col    <= '0;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
                ST_FETCH: col  <= col + 4'd1;
                ST_DRAIN: slot <= slot + 3'd1;
                default: ;
            endcase
        end
    end

    sprite_line_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (hcount),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_force (wr_force),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    assign sprite_pixel        = rd_data[3:0];
    assign sprite_pixel_active = rd_data[4];

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb/tb_sprite_line_engine.sv - directed self-checking bench for sprite_line_engine
module tb_sprite_line_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        new_line;
    logic        tbl_we;
    logic [2:0]  tbl_addr;
    logic [24:0] tbl_data;
    logic [11:0] rom_addr;
    logic [4:0]  rom_data;
    logic [3:0]  sprite_pixel;
    logic        sprite_pixel_active;
    logic        busy;
    logic        overrun;

    logic [4:0]  rom_mem [4096];
    logic [4:0]  exp_line [640];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          rom_chk = -1;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_line_engine dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .hcount              (hcount),
        .vcount              (vcount),
        .new_line            (new_line),
        .tbl_we              (tbl_we),
        .tbl_addr            (tbl_addr),
        .tbl_data            (tbl_data),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .sprite_pixel        (sprite_pixel),
        .sprite_pixel_active (sprite_pixel_active),
        .busy                (busy),
        .overrun             (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: all {1,7}; 1: index=icon; 2: index=col, icon 1 odd cols clear; 3: index=row
    task automatic rom_fill(input int mode);
        logic [11:0] a;
        for (int i = 0; i < 4096; i++) begin
            a = 12'(i);
            case (mode)
                0:       rom_mem[i] = 5'h17;
                1:       rom_mem[i] = {1'b1, a[11:8]};
                2:       rom_mem[i] = {(a[11:8] != 4'd1) || !a[0], a[3:0]};
                default: rom_mem[i] = {1'b1, a[7:4]};
            endcase
        end
    endtask

    task automatic tbl_write(input int s, input int en, input int x, input int y, input int icon);
        tbl_we   = 1'b1;
        tbl_addr = 3'(s);
        tbl_data = {1'(en), 10'(x), 10'(y), 4'(icon)};
        step();
        tbl_we   = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 640; i++) exp_line[i] = 5'h00;
    endtask

    task automatic run_line(input int v, input bit nl, input int h0);
        for (int h = h0; h < 800; h++) begin
            hcount   = 10'(h);
            vcount   = 10'(v);
            new_line = nl && (h == 640);
            step();
            if (h < 640)
                chk($sformatf("pix v%0d h%0d", v, h), {sprite_pixel_active, sprite_pixel}, exp_line[h]);
            else
                chk($sformatf("blank v%0d h%0d", v, h), {sprite_pixel_active, sprite_pixel}, 0);
            if (h == 641 && nl && rom_chk >= 0)
                chk($sformatf("rom_addr v%0d", v), rom_addr, rom_chk);
        end
        new_line = 1'b0;
        chk($sformatf("busy end v%0d", v), busy, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        hcount   = 10'd700;
        vcount   = 10'd0;
        new_line = 1'b0;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_data = '0;
        rom_fill(0);

        // Reset, then 640-cycle clear
        step();
        chk("rst busy", busy, 1);
        chk("rst overrun", overrun, 0);
        chk("rst rom_addr", rom_addr, 0);
        chk("rst pixel", {sprite_pixel_active, sprite_pixel}, 0);
        rst_n = 1'b1;
        repeat (639) step();
        chk("busy cycle 640", busy, 1);
        step();
        chk("busy cycle 641", busy, 0);
        clear_exp();
        run_line(0, 1'b1, 0);
        run_line(1, 1'b0, 0);

        // Single sprite x=100 y=50, index 7, lines 50..65
        tbl_write(0, 1, 100, 50, 2);
        clear_exp();
        rom_chk = 12'h200;
        run_line(49, 1'b1, 0);
        for (int l = 50; l <= 66; l++) begin
            clear_exp();
            if (l <= 65) for (int c = 0; c < 16; c++) exp_line[100 + c] = 5'h17;
            rom_chk = (l == 55) ? 12'h260 : -1;
            run_line(l, 1'b1, 0);
        end
        rom_chk = -1;

        // Overlap at x=200: slot 0 (index 3) beats slot 3 (index 9)
        rom_fill(1);
        tbl_write(0, 1, 200, 100, 3);
        tbl_write(3, 1, 200, 100, 9);
        clear_exp();
        run_line(99, 1'b1, 0);
        for (int c = 0; c < 16; c++) exp_line[200 + c] = 5'h13;
        run_line(100, 1'b0, 0);

        // Right-edge clip at x=630 and transparent odd columns at x=300
        rom_fill(2);
        tbl_write(0, 1, 630, 200, 5);
        tbl_write(1, 1, 300, 200, 1);
        tbl_write(3, 0, 0, 0, 0);
        clear_exp();
        run_line(199, 1'b1, 0);
        for (int c = 0; c < 10; c++) exp_line[630 + c] = {1'b1, 4'(c)};
        for (int c = 0; c < 16; c += 2) exp_line[300 + c] = {1'b1, 4'(c)};
        run_line(200, 1'b1, 0);
        run_line(201, 1'b1, 0);
        run_line(202, 1'b0, 0);

        // Frame wrap: y=0 drawn on line 0, y=520 not drawn on lines 0/1
        rom_fill(3);
        tbl_write(0, 1, 10, 0, 4);
        tbl_write(1, 1, 100, 520, 4);
        clear_exp();
        run_line(524, 1'b1, 0);
        for (int c = 0; c < 16; c++) exp_line[10 + c] = 5'h10;
        run_line(0, 1'b1, 0);
        for (int c = 0; c < 16; c++) exp_line[10 + c] = 5'h11;
        run_line(1, 1'b0, 0);

        // Eight hits, new_line held, cut off after 50 cycles
        rom_fill(1);
        for (int s = 0; s < 8; s++) tbl_write(s, 1, 100 * s, 300, s);
        hcount   = 10'd640;
        vcount   = 10'd299;
        new_line = 1'b1;
        repeat (50) step();
        chk("busy before abort", busy, 1);
        hcount   = 10'd0;
        new_line = 1'b0;
        step();
        chk("abort busy", busy, 0);
        chk("abort overrun", overrun, 1);
        chk("abort pix h0", {sprite_pixel_active, sprite_pixel}, 5'h10);
        clear_exp();
        for (int c = 0; c < 16; c++) exp_line[c] = 5'h10;
        for (int c = 0; c < 16; c++) exp_line[100 + c] = 5'h11;
        for (int c = 0; c < 11; c++) exp_line[200 + c] = 5'h12;
        run_line(300, 1'b0, 1);
        chk("overrun sticky", overrun, 1);

        // Reset in the middle of FETCH
        hcount   = 10'd640;
        vcount   = 10'd299;
        new_line = 1'b1;
        step();
        new_line = 1'b0;
        repeat (4) step();
        chk("mid fetch busy", busy, 1);
        chk("mid fetch rom_addr", rom_addr, 12'h003);
        rst_n = 1'b0;
        step();
        chk("rst2 busy", busy, 1);
        chk("rst2 overrun", overrun, 0);
        chk("rst2 rom_addr", rom_addr, 0);
        rst_n  = 1'b1;
        hcount = 10'd700;
        repeat (640) step();
        chk("rst2 clear done", busy, 0);
        clear_exp();
        run_line(299, 1'b1, 0);
        run_line(300, 1'b0, 0);
        chk("rst2 overrun end", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
